// File: rtl/data_memory_be_if.sv
// Bus between the MEM stage and data_memory_be.
//   master: drives clear_req, WE, funct3, A, WD; observes RD, misaligned, busy.
//   slave : the memory; drives RD, misaligned, busy.
interface data_memory_be_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32
);
   logic                  clear_req;
   logic                  WE;
   logic [2:0]            funct3;
   logic [ADDR_WIDTH-1:0] A;
   logic [DATA_WIDTH-1:0] WD;
   logic [DATA_WIDTH-1:0] RD;
   logic                  misaligned;
   logic                  busy;

   modport master (
      output clear_req, WE, funct3, A, WD,
      input  RD, misaligned, busy
   );

   modport slave (
      input  clear_req, WE, funct3, A, WD,
      output RD, misaligned, busy
   );
endinterface

// File: rtl/data_memory_be.sv
// Byte-enabled data memory for the MEM stage.
// Loads are combinational with sign/zero extension, stores are byte-lane
// masked on the rising edge, and a sequenced clear engine zeroes the array
// after reset (CLEAR_ON_RESET=1) or on clear_req.
// Ports:
//   clk   - clock
//   reset - asynchronous active-low reset (FSM and counter only, not the array)
//   bus   - data_memory_be_if.slave: clear_req, WE, funct3, A, WD in;
//           RD, misaligned, busy out
module data_memory_be #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned MEM_SIZE       = 256,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   data_memory_be_if.slave  bus
);

   localparam int unsigned NBYTES = DATA_WIDTH / 8;
   localparam int unsigned OFF_W  = $clog2(NBYTES);
   localparam int unsigned IDX_W  = $clog2(MEM_SIZE);

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   state_t                state;
   logic [IDX_W-1:0]      cnt;
   logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

   logic [ADDR_WIDTH-1:0] addr;
   logic [IDX_W-1:0]      idx;
   logic [OFF_W-1:0]      off;
   logic [1:0]            size;
   logic                  uns;
   logic                  mis;
   logic                  busy;
   logic                  st_en;
   logic [OFF_W-1:0]      align_mask;
   logic [NBYTES-1:0]     be;
   logic [DATA_WIDTH-1:0] wd_sh;
   logic [DATA_WIDTH-1:0] rd_sh;
   logic [DATA_WIDTH-1:0] keep;
   logic                  sbit;
   logic [DATA_WIDTH-1:0] rd;
   logic                  unused_addr;

   // Address decode; upper address bits wrap.
   assign addr        = bus.A;
   assign idx         = addr[OFF_W+IDX_W-1:OFF_W];
   assign off         = addr[OFF_W-1:0];
   assign size        = bus.funct3[1:0];
   assign uns         = bus.funct3[2];
   assign unused_addr = ^addr[ADDR_WIDTH-1:OFF_W+IDX_W];

   // Misalignment: offset not a multiple of the access size, an access wider
   // than the word, or an unsigned load of the full word width.
   always_comb begin
      align_mask = '0;
      case (size)
         2'd1:    align_mask = OFF_W'(1);
         2'd2:    align_mask = OFF_W'(3);
         2'd3:    align_mask = OFF_W'(7);
         default: align_mask = '0;
      endcase
      mis = (|(off & align_mask)) || (32'(size) > OFF_W) ||
            (uns && (32'(size) == OFF_W));
   end

   assign busy  = (state == S_CLEAR);
   assign st_en = (state == S_IDLE) && bus.WE && !mis;

   // Store lanes: bytes off .. off+2^size-1 take WD bytes 0 .. 2^size-1.
   always_comb begin
      wd_sh = bus.WD << {off, 3'b000};
      be    = '0;
      for (int unsigned b = 0; b < NBYTES; b++) begin
         be[b] = (b >= 32'(off)) && (b < (32'(off) + (32'd1 << size)));
      end
   end

   // Array write port: clear engine has priority; no reset on the array.
   always_ff @(posedge clk) begin
      if (state == S_CLEAR) begin
         mem[cnt] <= '0;
      end else if (st_en) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= wd_sh[8*b +: 8];
         end
      end
   end

   // Clear sequencer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            S_CLEAR: begin
               cnt <= cnt + IDX_W'(1);
               if (cnt == IDX_W'(MEM_SIZE - 1)) state <= S_IDLE;
            end
            default: begin
               if (bus.clear_req) begin
                  state <= S_CLEAR;
                  cnt   <= '0;
               end
            end
         endcase
      end
   end

   // Load: shift the addressed bytes down, then mask and extend. Reads see
   // pre-store contents in a collision cycle (no bypass).
   always_comb begin
      rd_sh = mem[idx] >> {off, 3'b000};
      keep  = '1;
      sbit  = 1'b0;
      case (size)
         2'd0: begin
            keep = DATA_WIDTH'(8'hFF);
            sbit = rd_sh[7];
         end
         2'd1: begin
            keep = DATA_WIDTH'(16'hFFFF);
            sbit = rd_sh[15];
         end
         2'd2: begin
            keep = DATA_WIDTH'(32'hFFFF_FFFF);
            sbit = rd_sh[31];
         end
         default: begin
            keep = '1;
            sbit = 1'b0;
         end
      endcase
      rd = (rd_sh & keep) | ({DATA_WIDTH{sbit & ~uns}} & ~keep);
   end

   assign bus.RD         = (busy || mis) ? '0 : rd;
   assign bus.misaligned = mis;
   assign bus.busy       = busy;

endmodule

// File: doc/data_memory_be.md
Name: data_memory_be

Overview:
- Next-generation data memory for the RV pipeline MEM stage.
- Adds byte, halfword and word (and doubleword when 64-bit) load/store with sign/zero extension.
- Flags misaligned accesses.
- Replaces the array-wide reset loop with a sequenced clear engine, runnable after reset or on request.
- Read stays combinational, so MEM-stage timing is unchanged.

Parameters:
- DATA_WIDTH, 32, word width in bits; legal values 32 or 64. NBYTES = DATA_WIDTH/8; OFF_W = log2(NBYTES).
- ADDR_WIDTH, 32, byte-address width.
- MEM_SIZE, 256, depth in words; power of two, >= 2. IDX_W = log2(MEM_SIZE).
- CLEAR_ON_RESET, 1, when 1 the clear engine starts after reset; when 0 the block comes up IDLE with contents undefined.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- clear_req  in  1  synchronous request to zero the whole array; sampled in IDLE only.
- WE  in  1  store enable (MemWriteM).
- funct3  in  3  access type: [1:0] size (0 byte, 1 half, 2 word, 3 double); [2] unsigned load.
- A  in  ADDR_WIDTH  byte address.
- WD  in  DATA_WIDTH  store data, right-aligned.
- RD  out  DATA_WIDTH  load data, extended to DATA_WIDTH.
- misaligned  out  1  access illegal for the current A/funct3.
- busy  out  1  clear engine active.

Behaviour:
- Decode
  - idx = A[OFF_W+IDX_W-1:OFF_W]; off = A[OFF_W-1:0]. Upper address bits are ignored, so addresses wrap modulo MEM_SIZE*NBYTES.
- misaligned (combinational)
  - Asserted when off is not a multiple of 2^size.
  - Also asserted when size=3 and DATA_WIDTH=32.
  - Also asserted when funct3[2]=1 and the size is the full word width (e.g. funct3=110 at DATA_WIDTH=32; funct3[2]=1 with size 3 at DATA_WIDTH=64).
- FSM states
  - CLEAR: cnt writes 0 to mem[cnt] each cycle.
  - IDLE: normal operation.
- Reset
  - reset=0 asynchronously forces state=CLEAR (CLEAR_ON_RESET=1) or IDLE (CLEAR_ON_RESET=0), with cnt=0.
  - Array contents are not touched asynchronously.
  - busy reset value is 1 or 0 respectively, following state.
- CLEAR state
  - Each rising edge writes mem[cnt] <= 0 and increments cnt.
  - On the edge that writes cnt=MEM_SIZE-1, the FSM moves to IDLE.
  - A full clear takes exactly MEM_SIZE cycles; busy=1 for exactly those cycles.
  - Asserting reset mid-clear restarts at cnt=0.
  - clear_req is ignored while in CLEAR.
- IDLE with clear_req=1
  - Next state is CLEAR with cnt=0; the store in that same cycle still executes.
- Store (IDLE, WE=1, misaligned=0)
  - Only the addressed bytes of mem[idx] are updated at the edge: bytes off .. off+2^size-1 take WD bytes 0 .. 2^size-1.
  - Other bytes of the word are preserved.
  - WE=1 with misaligned=1 writes nothing.
  - WE is ignored during CLEAR (store dropped; the pipeline stalls on busy).
- Load (combinational)
  - word = mem[idx]. Extract 2^size bytes starting at byte off.
  - funct3[2]=0: sign-extend to DATA_WIDTH; funct3[2]=1: zero-extend.
- RD forced to 0 when:
  - busy=1, or
  - misaligned=1, or
  - after an asynchronous reset with CLEAR_ON_RESET=1 until the clear completes.
- Read/write collision: a load and a store to the same word in one cycle returns the pre-store contents; new data is visible after the edge (no bypass).
- RD and misaligned are purely combinational from A, funct3, array and state. busy is a registered-state decode.

Test Plan:
- Reset clear: pulse reset low, release, with MEM_SIZE=256 -> busy=1 for exactly 256 cycles, then 0. Loads of A=0x000 and A=0x3FC then return 0. RD=0 throughout busy.
- Byte lanes: SW 0xDEADBEEF @0x10; SB WD=0x55 @0x12; SH WD=0xA1B2 @0x10. Then:
  - LW @0x10 -> 0xDE55A1B2
  - LB @0x13 -> 0xFFFFFFDE
  - LBU @0x13 -> 0x000000DE
  - LH @0x12 -> 0xFFFFDE55
- Misaligned: SW WD=0x12345678 @0x21 -> misaligned=1, mem[8] unchanged (0). LH @0x23 -> misaligned=1, RD=0. LH @0x22 -> misaligned=0.
- Collision and wrap:
  - With mem[4]=0x11111111, SW 0x22222222 @0x10 while loading @0x10 -> RD=0x11111111 that cycle, 0x22222222 next cycle.
  - SW 0x22222222 @0x410 (wraps) -> LW @0x10 reads 0x22222222.
- Clear request and mid-clear reset:
  - clear_req=1 for one cycle in IDLE with prior data -> busy 256 cycles, all words 0.
  - Assert reset at cycle 100 of a clear -> the clear restarts and busy lasts a full 256 cycles after release.
  - SW issued during busy is not stored.
- DATA_WIDTH=64 build: SD 0x0123456789ABCDEF @0x8 -> LW @0xC = 0x0000000001234567, LWU/LBU semantics hold, SD @0x4 -> misaligned=1.
